// File: rtl/vc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vc_mem_pkg
//  Description : Shared types and constants for the n-port test memory:
//                per-port FSM state encoding, LFSR width/taps and LFSR helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package vc_mem_pkg;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One step of a right-shifting Galois LFSR
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

    // Per-port seed; an all-zero seed would lock the LFSR, so it is replaced by 1
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base,
                                                    input int                port);
        logic [LFSR_W-1:0] s;
        s         = base ^ LFSR_W'(port);
        lfsr_seed = (s == '0) ? 16'h0001 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_mem_test_nport_if.sv
`default_nettype none
// ============================================================================
//  Module      : vc_mem_test_nport_if
//  Description : Bundled per-port request/response bus of the n-port test
//                memory. master = requester side, slave = memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vc_mem_test_nport_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_SZ   = 8,
    parameter int DATA_SZ   = 32
);
    logic [NUM_PORTS-1:0]         memreq_bits_rw;
    logic [NUM_PORTS*ADDR_SZ-1:0] memreq_bits_addr;
    logic [NUM_PORTS*DATA_SZ-1:0] memreq_bits_data;
    logic [NUM_PORTS-1:0]         memreq_val;
    logic [NUM_PORTS-1:0]         memreq_rdy;
    logic [NUM_PORTS*DATA_SZ-1:0] memresp_bits_data;
    logic [NUM_PORTS-1:0]         memresp_val;
    logic [NUM_PORTS-1:0]         memresp_rdy;

    modport master (
        output memreq_bits_rw, memreq_bits_addr, memreq_bits_data, memreq_val,
        output memresp_rdy,
        input  memreq_rdy, memresp_bits_data, memresp_val
    );

    modport slave (
        input  memreq_bits_rw, memreq_bits_addr, memreq_bits_data, memreq_val,
        input  memresp_rdy,
        output memreq_rdy, memresp_bits_data, memresp_val
    );
endinterface
`default_nettype wire

// File: rtl/vc_mem_test_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vc_mem_test_port_ctrl
//  Description : One port of the test memory: IDLE/WAIT/RESP FSM, random
//                service-delay counter, LFSR and request/response registers.
//                The memory itself lives in the parent; this block presents
//                an access strobe at the edge where the access happens.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_mem_test_port_ctrl
    import vc_mem_pkg::*;
#(
    parameter int                ADDR_SZ      = 8,
    parameter int                DATA_SZ      = 32,
    parameter int                RANDOM_DELAY = 0,
    parameter logic [LFSR_W-1:0] SEED         = 16'hACE1,
    parameter int                PORT_IDX     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_rw,
    input  logic [ADDR_SZ-1:0] req_addr,
    input  logic [DATA_SZ-1:0] req_data,
    input  logic               req_val,
    output logic               req_rdy,
    output logic [DATA_SZ-1:0] resp_data,
    output logic               resp_val,
    input  logic               resp_rdy,
    input  logic [DATA_SZ-1:0] mem_rdata,
    output logic               acc_wr,
    output logic [ADDR_SZ-1:0] acc_addr,
    output logic [DATA_SZ-1:0] acc_data
);

    localparam int                CNT_W  = (RANDOM_DELAY > 0) ? $clog2(RANDOM_DELAY + 1) : 1;
    localparam logic [LFSR_W-1:0] SEED_P = lfsr_seed(SEED, PORT_IDX);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic               rw_q, rw_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic [DATA_SZ-1:0] data_q, data_d;
    logic [DATA_SZ-1:0] resp_data_q, resp_data_d;
    logic               resp_val_q, resp_val_d;
    logic               rdy_q, rdy_d;

    logic               fire;
    logic [CNT_W-1:0]   delay_load;

    // Modulo by 1 yields 0, so the zero-delay configuration needs no special case
    assign delay_load = CNT_W'(32'(lfsr_q) % (RANDOM_DELAY + 1));
    assign fire       = req_val && rdy_q;

    // Next-state and datapath for the port FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        resp_val_d  = resp_val_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    data_d  = req_data;
                    cnt_d   = delay_load;
                    lfsr_d  = lfsr_next(lfsr_q);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rw_q) begin
                    state_d = ST_IDLE;
                end else begin
                    resp_data_d = mem_rdata;
                    resp_val_d  = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_rdy) begin
                    resp_val_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    // State registers; reset drops any in-flight request and pending response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lfsr_q      <= SEED_P;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            resp_val_q  <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
            resp_val_q  <= resp_val_d;
            rdy_q       <= rdy_d;
        end
    end

    assign req_rdy   = rdy_q;
    assign resp_val  = resp_val_q;
    assign resp_data = resp_data_q;
    assign acc_wr    = (state_q == ST_WAIT) && (cnt_q == '0) && rw_q;
    assign acc_addr  = addr_q;
    assign acc_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/vc_mem_test_nport.sv
`default_nettype none
// ============================================================================
//  Module      : vc_mem_test_nport
//  Description : Multi-port test memory with independent per-port FSMs and
//                optional random service delay. Holds the shared word array
//                and resolves same-edge writes (highest port wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_mem_test_nport
    import vc_mem_pkg::*;
#(
    parameter int                NUM_PORTS    = 2,
    parameter int                MEM_SZ       = 8,
    parameter int                ADDR_SZ      = 8,
    parameter int                DATA_SZ      = 32,
    parameter int                ADDR_SHIFT   = 2,
    parameter int                RANDOM_DELAY = 0,
    parameter logic [LFSR_W-1:0] SEED         = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    vc_mem_test_nport_if.slave    mem_if
);

    localparam int IDX_W = MEM_SZ - ADDR_SHIFT;
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_SZ-1:0] mem_q [DEPTH];

    logic               acc_wr    [NUM_PORTS];
    logic [ADDR_SZ-1:0] acc_addr  [NUM_PORTS];
    logic [DATA_SZ-1:0] acc_data  [NUM_PORTS];
    logic [IDX_W-1:0]   acc_idx   [NUM_PORTS];
    logic [DATA_SZ-1:0] rdata     [NUM_PORTS];
    logic               req_rdy   [NUM_PORTS];
    logic               resp_val  [NUM_PORTS];
    logic [DATA_SZ-1:0] resp_data [NUM_PORTS];
    logic               unused_addr_bits;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            // Bits above MEM_SZ are dropped, so addresses wrap modulo memory size
            assign acc_idx[p] = acc_addr[p][MEM_SZ-1:ADDR_SHIFT];
            // Asynchronous read sees pre-write contents at the access edge
            assign rdata[p]   = mem_q[acc_idx[p]];

            vc_mem_test_port_ctrl #(
                .ADDR_SZ      (ADDR_SZ),
                .DATA_SZ      (DATA_SZ),
                .RANDOM_DELAY (RANDOM_DELAY),
                .SEED         (SEED),
                .PORT_IDX     (p)
            ) u_ctrl (
                .clk       (clk),
                .reset     (reset),
                .req_rw    (mem_if.memreq_bits_rw[p]),
                .req_addr  (mem_if.memreq_bits_addr[p*ADDR_SZ +: ADDR_SZ]),
                .req_data  (mem_if.memreq_bits_data[p*DATA_SZ +: DATA_SZ]),
                .req_val   (mem_if.memreq_val[p]),
                .req_rdy   (req_rdy[p]),
                .resp_data (resp_data[p]),
                .resp_val  (resp_val[p]),
                .resp_rdy  (mem_if.memresp_rdy[p]),
                .mem_rdata (rdata[p]),
                .acc_wr    (acc_wr[p]),
                .acc_addr  (acc_addr[p]),
                .acc_data  (acc_data[p])
            );
        end
    endgenerate

    // Pack per-port results onto the bus vectors
    always_comb begin
        mem_if.memreq_rdy        = '0;
        mem_if.memresp_val       = '0;
        mem_if.memresp_bits_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            mem_if.memreq_rdy[p]                           = req_rdy[p];
            mem_if.memresp_val[p]                          = resp_val[p];
            mem_if.memresp_bits_data[p*DATA_SZ +: DATA_SZ] = resp_data[p];
        end
    end

    // Sub-word and out-of-range address bits have no effect on the array
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            unused_addr_bits = unused_addr_bits ^ (^acc_addr[p]);
        end
    end

    // Ascending port loop: a later (higher) port overrides a lower one on the same index
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc_wr[p]) begin
                mem_q[acc_idx[p]] <= acc_data[p];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vc_mem_test_nport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_mem_test_nport
//  Description : Self-checking bench for vc_mem_test_nport: directed vector
//                table plus multi-cycle corner sequences on a zero-delay
//                instance, and a scoreboarded random run on a delayed one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_mem_test_nport;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vc_mem_test_nport_if #(.NUM_PORTS(2), .ADDR_SZ(AW), .DATA_SZ(DW)) m0 ();
    vc_mem_test_nport_if #(.NUM_PORTS(2), .ADDR_SZ(AW), .DATA_SZ(DW)) m7 ();

    vc_mem_test_nport #(
        .NUM_PORTS(2), .MEM_SZ(8), .ADDR_SZ(AW), .DATA_SZ(DW),
        .ADDR_SHIFT(2), .RANDOM_DELAY(0), .SEED(16'hACE1)
    ) dut0 (.clk(clk), .reset(reset), .mem_if(m0));

    vc_mem_test_nport #(
        .NUM_PORTS(2), .MEM_SZ(8), .ADDR_SZ(AW), .DATA_SZ(DW),
        .ADDR_SHIFT(2), .RANDOM_DELAY(7), .SEED(16'hACE1)
    ) dut7 (.clk(clk), .reset(reset), .mem_if(m7));

    typedef struct {
        int          p;
        logic        rw;
        logic [9:0]  addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rdy0(input int p);
        int n = 0;
        while (m0.memreq_rdy[p] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rdy0 timeout", 0, 1);
    endtask

    task automatic do_write0(input int p, input logic [9:0] a, input logic [31:0] d, input string name);
        wait_rdy0(p);
        m0.memreq_bits_rw[p]           = 1'b1;
        m0.memreq_bits_addr[p*AW +: AW] = a;
        m0.memreq_bits_data[p*DW +: DW] = d;
        m0.memreq_val[p]               = 1'b1;
        @(negedge clk);
        m0.memreq_val[p] = 1'b0;
        check({name, " busy"}, 64'(m0.memreq_rdy[p]), 0);
        @(negedge clk);
        check({name, " rdy back"}, 64'(m0.memreq_rdy[p]), 1);
    endtask

    task automatic do_read0(input int p, input logic [9:0] a, input logic [31:0] exp, input string name);
        wait_rdy0(p);
        m0.memreq_bits_rw[p]           = 1'b0;
        m0.memreq_bits_addr[p*AW +: AW] = a;
        m0.memreq_val[p]               = 1'b1;
        @(negedge clk);
        m0.memreq_val[p] = 1'b0;
        check({name, " val early"}, 64'(m0.memresp_val[p]), 0);
        @(negedge clk);
        check({name, " val"}, 64'(m0.memresp_val[p]), 1);
        check({name, " data"}, 64'(m0.memresp_bits_data[p*DW +: DW]), 64'(exp));
        @(negedge clk);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        lfsr_step = (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [15:0] lf [2];
        logic [31:0] model [64];

        m0.memreq_bits_rw = '0; m0.memreq_bits_addr = '0; m0.memreq_bits_data = '0;
        m0.memreq_val = '0; m0.memresp_rdy = 2'b11;
        m7.memreq_bits_rw = '0; m7.memreq_bits_addr = '0; m7.memreq_bits_data = '0;
        m7.memreq_val = '0; m7.memresp_rdy = 2'b11;

        vecs[0] = '{0, 1'b1, 10'h004, 32'hDEADBEEF};
        vecs[1] = '{0, 1'b0, 10'h004, 32'hDEADBEEF};
        vecs[2] = '{1, 1'b1, 10'h3FC, 32'hCAFEF00D};
        vecs[3] = '{0, 1'b0, 10'h0FC, 32'hCAFEF00D};
        vecs[4] = '{1, 1'b1, 10'h118, 32'h01234567};
        vecs[5] = '{1, 1'b0, 10'h01B, 32'h01234567};
        vecs[6] = '{0, 1'b0, 10'h206, 32'hDEADBEEF};
        vecs[7] = '{1, 1'b1, 10'h010, 32'h00000000};
        vecs[8] = '{0, 1'b0, 10'h010, 32'h00000000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rdy0", 64'(m0.memreq_rdy), 0);
        check("reset val0", 64'(m0.memresp_val), 0);
        check("reset data0", 64'(m0.memresp_bits_data), 0);
        check("reset rdy7", 64'(m7.memreq_rdy), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rdy after reset", 64'(m0.memreq_rdy), 64'h3);

        // Directed single-port vectors
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rw) do_write0(vecs[i].p, vecs[i].addr, vecs[i].data, $sformatf("vec%0d wr", i));
            else            do_read0(vecs[i].p, vecs[i].addr, vecs[i].data, $sformatf("vec%0d rd", i));
        end

        // Same-edge writes to one index: port 1 wins
        m0.memreq_bits_rw = 2'b11;
        m0.memreq_bits_addr = {10'h008, 10'h008};
        m0.memreq_bits_data = {32'h22222222, 32'h11111111};
        m0.memreq_val = 2'b11;
        @(negedge clk);
        m0.memreq_val = 2'b00;
        @(negedge clk);
        do_read0(0, 10'h008, 32'h22222222, "prio rd");

        // Same-edge read and write to one index: read returns old data
        do_write0(0, 10'h00C, 32'hA5A5A5A5, "rw pre");
        m0.memreq_bits_rw = 2'b10;
        m0.memreq_bits_addr = {10'h00C, 10'h00C};
        m0.memreq_bits_data = {32'h5A5A5A5A, 32'h0};
        m0.memreq_val = 2'b11;
        @(negedge clk);
        m0.memreq_val = 2'b00;
        @(negedge clk);
        check("rw old val", 64'(m0.memresp_val[0]), 1);
        check("rw old data", 64'(m0.memresp_bits_data[31:0]), 64'hA5A5A5A5);
        @(negedge clk);
        do_read0(1, 10'h00C, 32'h5A5A5A5A, "rw new rd");

        // Stalled response on port 1 while port 0 keeps working
        m0.memresp_rdy[1] = 1'b0;
        m0.memreq_bits_rw[1] = 1'b0;
        m0.memreq_bits_addr[19:10] = 10'h004;
        m0.memreq_val[1] = 1'b1;
        @(negedge clk);
        m0.memreq_val[1] = 1'b0;
        @(negedge clk);
        check("stall val", 64'(m0.memresp_val[1]), 1);
        check("stall data", 64'(m0.memresp_bits_data[63:32]), 64'hDEADBEEF);
        held = m0.memresp_bits_data[63:32];
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("stall hold data", 64'(m0.memresp_bits_data[63:32]), 64'(held));
                    check("stall hold rdy", 64'(m0.memreq_rdy[1]), 0);
                end
            end
            begin
                do_read0(0, 10'h004, 32'hDEADBEEF, "stall p0 rd1");
                do_read0(0, 10'h118, 32'h01234567, "stall p0 rd2");
                do_read0(0, 10'h00C, 32'h5A5A5A5A, "stall p0 rd3");
            end
        join
        check("stall val end", 64'(m0.memresp_val[1]), 1);
        m0.memresp_rdy[1] = 1'b1;
        @(negedge clk);
        check("stall release val", 64'(m0.memresp_val[1]), 0);
        check("stall release rdy", 64'(m0.memreq_rdy[1]), 1);

        // Reset during the WAIT of a write; port 1 holds a pending response
        do_write0(0, 10'h010, 32'h0, "pre-reset wr");
        m0.memresp_rdy[1] = 1'b0;
        m0.memreq_bits_rw[1] = 1'b0;
        m0.memreq_bits_addr[19:10] = 10'h004;
        m0.memreq_val[1] = 1'b1;
        @(negedge clk);
        m0.memreq_val[1] = 1'b0;
        @(negedge clk);
        m0.memreq_bits_rw[0] = 1'b1;
        m0.memreq_bits_addr[9:0] = 10'h010;
        m0.memreq_bits_data[31:0] = 32'h12345678;
        m0.memreq_val[0] = 1'b1;
        @(negedge clk);
        m0.memreq_val[0] = 1'b0;
        check("pre-reset pending", 64'(m0.memresp_val[1]), 1);
        reset = 1'b1;
        #1;
        check("mid reset rdy", 64'(m0.memreq_rdy), 0);
        check("mid reset val", 64'(m0.memresp_val), 0);
        check("mid reset data", 64'(m0.memresp_bits_data), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m0.memresp_rdy[1] = 1'b1;
        @(negedge clk);
        check("post reset rdy", 64'(m0.memreq_rdy), 64'h3);
        check("post reset val", 64'(m0.memresp_val), 0);
        do_read0(0, 10'h010, 32'h0, "post reset rd");

        // Random run on the delayed instance against a scoreboard and LFSR model
        lf[0] = 16'hACE1;
        lf[1] = 16'hACE0;
        for (int i = 0; i < 1064; i++) begin
            int          p;
            int          n;
            int          expd;
            logic        rw;
            logic [9:0]  a;
            logic [31:0] d;
            p = $urandom_range(0, 1);
            if (i < 64) begin
                rw = 1'b1;
                a  = 10'((i * 4) + ($urandom_range(0, 3) << 8));
            end else begin
                rw = 1'($urandom_range(0, 1));
                a  = 10'($urandom_range(0, 1023));
            end
            d    = $urandom;
            expd = int'(lf[p] % 16'd8);
            lf[p] = lfsr_step(lf[p]);
            n = 0;
            while (m7.memreq_rdy[p] !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) check("rnd rdy timeout", 0, 1);
            m7.memreq_bits_rw[p]           = rw;
            m7.memreq_bits_addr[p*AW +: AW] = a;
            m7.memreq_bits_data[p*DW +: DW] = d;
            m7.memreq_val[p]               = 1'b1;
            @(negedge clk);
            m7.memreq_val[p] = 1'b0;
            n = 0;
            if (rw) begin
                while (m7.memreq_rdy[p] !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                model[a[7:2]] = d;
            end else begin
                while (m7.memresp_val[p] !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("rnd rd data", 64'(m7.memresp_bits_data[p*DW +: DW]), 64'(model[a[7:2]]));
                @(negedge clk);
            end
            check("rnd delay", 64'(n - 1), 64'(expd));
            check("rnd delay range", 64'((n >= 1) && (n <= 8)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
